pdm_mic_rx: RTL



---
 rtl/pdm_pkg.sv | 26 ++
 rtl/pdm_mic_rx_if.sv | 26 ++
 rtl/pdm_clk_gen.sv | 40 ++++
 rtl/pdm_mic_rx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants, width helpers and alarm state encoding for the PDM microphone receiver.
package pdm_pkg;

   localparam int HALF_PERIOD   = 40;
   localparam int DECIM         = 128;
   localparam int FRAME_SAMPLES = 16;
   localparam int HOLD_FRAMES   = 4;

   localparam int SAMPLE_W = $clog2(DECIM + 1);
   localparam int DEV_W    = 7;

   typedef enum logic [1:0] {
      QUIET = 2'd0,
      LOUD  = 2'd1,
      HOLD  = 2'd2
   } alarm_state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int abs_diff(input int a, input int b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/pdm_mic_rx_if.sv
// Microphone pins, threshold input and PCM/level/alarm outputs of the PDM receiver.
interface pdm_mic_rx_if #(
   parameter int SAMPLE_W = pdm_pkg::SAMPLE_W
);

   logic                      M_DATA;
   logic [pdm_pkg::DEV_W-1:0] thresh;
   logic                      M_CLK;
   logic                      M_LRSEL;
   logic [SAMPLE_W-1:0]       sample;
   logic                      sample_valid;
   logic [pdm_pkg::DEV_W-1:0] level;
   logic                      level_valid;
   logic                      sound_alarm;

   modport master (
      input  M_DATA, thresh,
      output M_CLK, M_LRSEL, sample, sample_valid, level, level_valid, sound_alarm
   );

   modport slave (
      output M_DATA, thresh,
      input  M_CLK, M_LRSEL, sample, sample_valid, level, level_valid, sound_alarm
   );

endinterface

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider; rise_stb_o marks the last clk_fpga cycle before each M_CLK rise.
module pdm_clk_gen #(
   parameter int HALF_PERIOD = pdm_pkg::HALF_PERIOD
) (
   input  logic clk_fpga,
   input  logic reset,
   output logic m_clk_o,
   output logic rise_stb_o
);
   import pdm_pkg::*;

   localparam int             DIV_W    = cnt_w(HALF_PERIOD);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             m_clk_q, m_clk_d;
   logic             terminal;

   assign terminal = (div_cnt_q == DIV_LAST);

   always_comb begin
      div_cnt_d = terminal ? '0 : div_cnt_q + 1'b1;
      m_clk_d   = terminal ? ~m_clk_q : m_clk_q;
   end

   // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         div_cnt_q <= '0;
         m_clk_q   <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         m_clk_q   <= m_clk_d;
      end
   end

   assign m_clk_o    = m_clk_q;
   assign rise_stb_o = terminal & ~m_clk_q;

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: boxcar decimation to PCM, per-frame peak deviation and a held
// loud-sound alarm with a programmable threshold.
module pdm_mic_rx #(
   parameter int HALF_PERIOD   = pdm_pkg::HALF_PERIOD,
   parameter int DECIM         = pdm_pkg::DECIM,
   parameter int FRAME_SAMPLES = pdm_pkg::FRAME_SAMPLES,
   parameter int HOLD_FRAMES   = pdm_pkg::HOLD_FRAMES
) (
   input logic          clk_fpga,
   input logic          reset,
   pdm_mic_rx_if.master bus
);
   import pdm_pkg::*;

   localparam int SMP_W  = $clog2(DECIM + 1);
   localparam int BIT_W  = cnt_w(DECIM);
   localparam int FRM_W  = cnt_w(FRAME_SAMPLES);
   localparam int HOLD_W = cnt_w(HOLD_FRAMES);

   logic m_clk, rise_stb;

   pdm_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
      .clk_fpga   (clk_fpga),
      .reset      (reset),
      .m_clk_o    (m_clk),
      .rise_stb_o (rise_stb)
   );

   logic sync1_q, sync2_q;

   // NOTE: synchronizer flops are left without reset; they only retime M_DATA and flush in two cycles.
   always_ff @(posedge clk_fpga) begin
      sync1_q <= bus.M_DATA;
      sync2_q <= sync1_q;
   end

   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [SMP_W-1:0] ones_acc_q, ones_acc_d;
   logic [SMP_W-1:0] sample_q, sample_d;
   logic             sample_valid_q, sample_valid_d;

   // NOTE: every _d gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      bit_cnt_d      = bit_cnt_q;
      ones_acc_d     = ones_acc_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      if (rise_stb) begin
         if (bit_cnt_q == BIT_W'(DECIM - 1)) begin
            sample_d       = ones_acc_q + SMP_W'(sync2_q);
            sample_valid_d = 1'b1;
            ones_acc_d     = '0;
            bit_cnt_d      = '0;
         end else begin
            ones_acc_d = ones_acc_q + SMP_W'(sync2_q);
            bit_cnt_d  = bit_cnt_q + 1'b1;
         end
      end
   end

   logic [DEV_W-1:0] dev, peak_max;
   logic [DEV_W-1:0] peak_q, peak_d;
   logic [FRM_W-1:0] samp_cnt_q, samp_cnt_d;
   logic [DEV_W-1:0] level_q, level_d;
   logic             level_valid_q, level_valid_d;

   assign dev      = DEV_W'(abs_diff(int'(sample_q), DECIM / 2));
   assign peak_max = (dev > peak_q) ? dev : peak_q;

   always_comb begin
      peak_d        = peak_q;
      samp_cnt_d    = samp_cnt_q;
      level_d       = level_q;
      level_valid_d = 1'b0;
      if (sample_valid_q) begin
         if (samp_cnt_q == FRM_W'(FRAME_SAMPLES - 1)) begin
            level_d       = peak_max;
            level_valid_d = 1'b1;
            peak_d        = '0;
            samp_cnt_d    = '0;
         end else begin
            peak_d     = peak_max;
            samp_cnt_d = samp_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         bit_cnt_q      <= '0;
         ones_acc_q     <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         peak_q         <= '0;
         samp_cnt_q     <= '0;
         level_q        <= '0;
         level_valid_q  <= 1'b0;
      end else begin
         bit_cnt_q      <= bit_cnt_d;
         ones_acc_q     <= ones_acc_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         peak_q         <= peak_d;
         samp_cnt_q     <= samp_cnt_d;
         level_q        <= level_d;
         level_valid_q  <= level_valid_d;
      end
   end

   alarm_state_e      state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              alarm_q, alarm_d;
   logic              loud;

   assign loud = (level_q >= bus.thresh);

   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         state_q    <= QUIET;
         hold_cnt_q <= '0;
         alarm_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         alarm_q    <= alarm_d;
      end
   end

   // A loud frame arriving during HOLD wins; the hold count is reloaded on the next exit from LOUD.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (level_valid_q) begin
         case (state_q)
            QUIET: if (loud) state_d = LOUD;
            LOUD: begin
               if (!loud) begin
                  state_d    = HOLD;
                  hold_cnt_d = HOLD_W'(HOLD_FRAMES - 1);
               end
            end
            HOLD: begin
               if (loud)                  state_d    = LOUD;
               else if (hold_cnt_q == '0) state_d    = QUIET;
               else                       hold_cnt_d = hold_cnt_q - 1'b1;
            end
            default: state_d = QUIET;
         endcase
      end
   end

   always_comb begin
      alarm_d = (state_d != QUIET);
   end

   assign bus.M_CLK        = m_clk;
   assign bus.M_LRSEL      = 1'b0;
   assign bus.sample       = sample_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.level        = level_q;
   assign bus.level_valid  = level_valid_q;
   assign bus.sound_alarm  = alarm_q;

endmodule
